// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter.
// A WIDTH-bit word is accepted over a valid/ready handshake and is then shifted
// out one bit per enabled clock. The sout_valid strobe qualifies each bit, and
// done marks the final bit. All outputs come straight from flops.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             in_ready_r, in_ready_s;
  logic             sout_r, sout_s;
  logic             sout_valid_r, sout_valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state and next-output logic. Defaults hold the state and clear the strobes.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    cnt_s        = cnt_r;
    in_ready_s   = in_ready_r;
    sout_s       = sout_r;
    sout_valid_s = 1'b0;
    busy_s       = busy_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          // Accept the word. en has no effect on acceptance.
          shreg_s    = din;
          cnt_s      = CW'(WIDTH);
          state_s    = SHIFT;
          in_ready_s = 1'b0;
          busy_s     = 1'b1;
        end else begin
          in_ready_s = 1'b1;
          busy_s     = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_r == CW'(0)) begin
          // The last bit went out on the previous edge. Reopen the input.
          state_s    = IDLE;
          in_ready_s = 1'b1;
          busy_s     = 1'b0;
        end else if (en) begin
          if (MSB_FIRST) begin
            sout_s  = shreg_r[WIDTH-1];
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          end else begin
            sout_s  = shreg_r[0];
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
          end
          sout_valid_s = 1'b1;
          cnt_s        = cnt_r - CW'(1);
          done_s       = (cnt_r == CW'(1));
        end else begin
          // Paused: sout keeps its last bit, and the counter and data are frozen.
          sout_s = sout_r;
        end
      end
      default: begin
        state_s    = IDLE;
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with a synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      in_ready_r   <= 1'b1;
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      cnt_r        <= cnt_s;
      in_ready_r   <= in_ready_s;
      sout_r       <= sout_s;
      sout_valid_r <= sout_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign sout       = sout_r;
  assign sout_valid = sout_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
